// File: rtl/stream_rr_arbiter.sv
// Packet-atomic round-robin arbiter that merges NUM_REQ valid/ready streams
// into one registered output slice, tagging each beat with its source index.
module stream_rr_arbiter #(
   parameter  int NUM_REQ    = 4,
   parameter  int DATA_WIDTH = 32,
   localparam int ID_WIDTH   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            in_valid_i,
   output logic [NUM_REQ-1:0]            in_ready_o,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] in_data_i,
   input  logic [NUM_REQ-1:0]            in_last_i,
   output logic                          out_valid_o,
   input  logic                          out_ready_i,
   output logic [DATA_WIDTH-1:0]         out_data_o,
   output logic                          out_last_o,
   output logic [ID_WIDTH-1:0]           out_id_o
);

   logic                  lock_q, lock_d;
   logic [ID_WIDTH-1:0]   lockId_q, lockId_d;
   logic [ID_WIDTH-1:0]   rrPtr_q, rrPtr_d;
   logic                  outValid_q, outValid_d;
   logic [DATA_WIDTH-1:0] outData_q, outData_d;
   logic                  outLast_q, outLast_d;
   logic [ID_WIDTH-1:0]   outId_q, outId_d;

   logic                  load;
   logic                  accept;
   logic                  grantValid;
   logic [ID_WIDTH-1:0]   grantIdx;
   logic [ID_WIDTH-1:0]   scanIdx;
   logic [ID_WIDTH-1:0]   nextPtr;

   assign load   = ~outValid_q | out_ready_i;
   assign accept = grantValid & load;

   // Scanning from the far end down lets the requester closest to rrPtr_q win.
   always_comb begin
      grantValid = 1'b0;
      grantIdx   = '0;
      scanIdx    = '0;
      if (lock_q) begin
         if (in_valid_i[lockId_q]) begin
            grantValid = 1'b1;
            grantIdx   = lockId_q;
         end
      end else begin
         for (int k = NUM_REQ - 1; k >= 0; k--) begin
            scanIdx = ID_WIDTH'((int'(rrPtr_q) + k) % NUM_REQ);
            if (in_valid_i[scanIdx]) begin
               grantValid = 1'b1;
               grantIdx   = scanIdx;
            end
         end
      end
   end

   always_comb begin
      in_ready_o = '0;
      if (accept && !rst) begin
         in_ready_o[grantIdx] = 1'b1;
      end
   end

   assign nextPtr = ID_WIDTH'((int'(grantIdx) + 1) % NUM_REQ);

   // A beat may enter while the old one drains, which keeps full throughput.
   always_comb begin
      lock_d     = lock_q;
      lockId_d   = lockId_q;
      rrPtr_d    = rrPtr_q;
      outValid_d = outValid_q;
      outData_d  = outData_q;
      outLast_d  = outLast_q;
      outId_d    = outId_q;
      if (accept) begin
         outValid_d = 1'b1;
         outData_d  = in_data_i[int'(grantIdx)*DATA_WIDTH +: DATA_WIDTH];
         outLast_d  = in_last_i[grantIdx];
         outId_d    = grantIdx;
         if (in_last_i[grantIdx]) begin
            lock_d  = 1'b0;
            rrPtr_d = nextPtr;
         end else begin
            lock_d   = 1'b1;
            lockId_d = grantIdx;
         end
      end else if (out_ready_i) begin
         outValid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lock_q     <= 1'b0;
         lockId_q   <= '0;
         rrPtr_q    <= '0;
         outValid_q <= 1'b0;
         outData_q  <= '0;
         outLast_q  <= 1'b0;
         outId_q    <= '0;
      end else begin
         lock_q     <= lock_d;
         lockId_q   <= lockId_d;
         rrPtr_q    <= rrPtr_d;
         outValid_q <= outValid_d;
         outData_q  <= outData_d;
         outLast_q  <= outLast_d;
         outId_q    <= outId_d;
      end
   end

   assign out_valid_o = outValid_q;
   assign out_data_o  = outData_q;
   assign out_last_o  = outLast_q;
   assign out_id_o    = outId_q;

   readyOneHot: assert property (@(posedge clk) disable iff (rst)
      $onehot0(in_ready_o));

   stallStable: assert property (@(posedge clk) disable iff (rst)
      (out_valid_o && !out_ready_i) |=>
         ($stable(out_data_o) && $stable(out_last_o) && $stable(out_id_o)));

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Directed bench for stream_rr_arbiter: requester queues drive the inputs and a
// monitor compares every delivered beat against a hand-built expected queue.
module tb_stream_rr_arbiter;

   localparam int NR = 4;
   localparam int DW = 32;
   localparam int IW = 2;

   logic             clk;
   logic             rst;
   logic [NR-1:0]    in_valid_i;
   logic [NR-1:0]    in_ready_o;
   logic [NR*DW-1:0] in_data_i;
   logic [NR-1:0]    in_last_i;
   logic             out_valid_o;
   logic             out_ready_i;
   logic [DW-1:0]    out_data_o;
   logic             out_last_o;
   logic [IW-1:0]    out_id_o;

   stream_rr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW)) dut (
      .clk(clk),
      .rst(rst),
      .in_valid_i(in_valid_i),
      .in_ready_o(in_ready_o),
      .in_data_i(in_data_i),
      .in_last_i(in_last_i),
      .out_valid_o(out_valid_o),
      .out_ready_i(out_ready_i),
      .out_data_o(out_data_o),
      .out_last_o(out_last_o),
      .out_id_o(out_id_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Per-requester pending beats {last, data}, and expected output {id, last, data}.
   logic [DW:0]      reqQ[NR][$];
   logic [IW+DW:0]   expQ[$];
   logic [NR-1:0]    hold;

   int               checks = 0;
   int               errors = 0;
   int               acceptCycles;
   logic [NR-1:0]    lastReady;
   logic             lastOutValid;
   logic [DW-1:0]    lastData;

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic pushBeat(input int r, input logic [DW-1:0] data, input logic last);
      reqQ[r].push_back({last, data});
   endtask

   task automatic expectBeat(input int id, input logic [DW-1:0] data, input logic last);
      expQ.push_back({IW'(id), last, data});
   endtask

   task automatic drive();
      for (int i = 0; i < NR; i++) begin
         in_valid_i[i] = (reqQ[i].size() > 0) && !hold[i];
         if (reqQ[i].size() > 0) begin
            in_data_i[i*DW +: DW] = reqQ[i][0][DW-1:0];
            in_last_i[i]          = reqQ[i][0][DW];
         end else begin
            in_data_i[i*DW +: DW] = '0;
            in_last_i[i]          = 1'b0;
         end
      end
   endtask

   // Runs n cycles; handshakes are sampled on the falling edge and consumed at the rising edge.
   task automatic applyStimulus(input int n);
      logic [NR-1:0] fire;
      for (int c = 0; c < n; c++) begin
         drive();
         @(negedge clk);
         fire         = in_valid_i & in_ready_o;
         lastReady    = in_ready_o;
         lastOutValid = out_valid_o;
         lastData     = out_data_o;
         if (fire != '0) acceptCycles++;
         @(posedge clk);
         for (int i = 0; i < NR; i++) begin
            if (fire[i]) void'(reqQ[i].pop_front());
         end
         #1;
         drive();
      end
   endtask

   // Monitor: every delivered beat must match the head of the expected queue.
   initial begin
      logic [IW+DW:0] exp;
      forever begin
         @(negedge clk);
         if (!rst && out_valid_o && out_ready_i) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpected beat", {out_id_o, out_last_o, out_data_o}, 64'hDEAD);
            end else begin
               exp = expQ.pop_front();
               checkOutput("beat id",   out_id_o,   exp[IW+DW:DW+1]);
               checkOutput("beat last", out_last_o, exp[DW]);
               checkOutput("beat data", out_data_o, exp[DW-1:0]);
            end
         end
      end
   end

   initial begin
      rst          = 1'b0;
      out_ready_i  = 1'b1;
      hold         = '0;
      in_valid_i   = '0;
      in_data_i    = '0;
      in_last_i    = '0;
      acceptCycles = 0;

      // Reset then idle
      #1 rst = 1'b1;
      #2;
      checkOutput("reset out_valid", out_valid_o, 0);
      checkOutput("reset out_data",  out_data_o,  0);
      checkOutput("reset out_last",  out_last_o,  0);
      checkOutput("reset out_id",    out_id_o,    0);
      checkOutput("reset in_ready",  in_ready_o,  0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      applyStimulus(3);
      checkOutput("idle out_valid", lastOutValid, 0);
      checkOutput("idle in_ready",  lastReady,    0);

      // Round-robin fairness with single-beat packets
      for (int s = 0; s < 3; s++) begin
         for (int i = 0; i < NR; i++) begin
            pushBeat(i, DW'(32'h100 * i + s), 1'b1);
            expectBeat(i, DW'(32'h100 * i + s), 1'b1);
         end
      end
      acceptCycles = 0;
      applyStimulus(12);
      checkOutput("rr throughput", acceptCycles, 12);
      applyStimulus(2);

      // Packet lock: req1 holds the grant for its three beats
      pushBeat(0, 32'hA0, 1'b1); pushBeat(0, 32'hA1, 1'b1);
      pushBeat(1, 32'hB0, 1'b0); pushBeat(1, 32'hB1, 1'b0); pushBeat(1, 32'hB2, 1'b1);
      pushBeat(2, 32'hC0, 1'b1);
      pushBeat(3, 32'hD0, 1'b1);
      expectBeat(0, 32'hA0, 1'b1);
      expectBeat(1, 32'hB0, 1'b0);
      expectBeat(1, 32'hB1, 1'b0);
      expectBeat(1, 32'hB2, 1'b1);
      expectBeat(2, 32'hC0, 1'b1);
      expectBeat(3, 32'hD0, 1'b1);
      expectBeat(0, 32'hA1, 1'b1);
      acceptCycles = 0;
      applyStimulus(7);
      checkOutput("lock throughput", acceptCycles, 7);
      applyStimulus(2);

      // Mid-packet gap on the locked requester
      pushBeat(1, 32'hE0, 1'b0); pushBeat(1, 32'hE1, 1'b0); pushBeat(1, 32'hE2, 1'b1);
      pushBeat(0, 32'hF0, 1'b1);
      pushBeat(2, 32'h60, 1'b1);
      expectBeat(1, 32'hE0, 1'b0);
      expectBeat(1, 32'hE1, 1'b0);
      expectBeat(1, 32'hE2, 1'b1);
      expectBeat(2, 32'h60, 1'b1);
      expectBeat(0, 32'hF0, 1'b1);
      applyStimulus(1);
      hold[1] = 1'b1;
      applyStimulus(1);
      checkOutput("gap in_ready", lastReady, 0);
      hold[1] = 1'b0;
      applyStimulus(1);
      checkOutput("gap bubble", lastOutValid, 0);
      applyStimulus(3);
      applyStimulus(2);

      // Backpressure holding 0xA5
      pushBeat(1, 32'hA5, 1'b1);
      expectBeat(1, 32'hA5, 1'b1);
      applyStimulus(1);
      pushBeat(2, 32'h77, 1'b1);
      expectBeat(2, 32'h77, 1'b1);
      out_ready_i = 1'b0;
      for (int s = 0; s < 5; s++) begin
         applyStimulus(1);
         checkOutput("stall in_ready",  lastReady,    0);
         checkOutput("stall out_data",  lastData,     32'hA5);
         checkOutput("stall out_valid", lastOutValid, 1);
      end
      out_ready_i = 1'b1;
      acceptCycles = 0;
      applyStimulus(1);
      checkOutput("drain and accept", acceptCycles, 1);
      applyStimulus(2);

      // Wrap-around and priority from rr_ptr=3
      pushBeat(2, 32'h20, 1'b1);
      expectBeat(2, 32'h20, 1'b1);
      applyStimulus(1);
      pushBeat(0, 32'h01, 1'b1);
      pushBeat(3, 32'h30, 1'b0); pushBeat(3, 32'h31, 1'b1);
      expectBeat(3, 32'h30, 1'b0);
      expectBeat(3, 32'h31, 1'b1);
      expectBeat(0, 32'h01, 1'b1);
      applyStimulus(3);
      applyStimulus(2);

      // Reset in the middle of req2's packet
      pushBeat(2, 32'h90, 1'b0); pushBeat(2, 32'h91, 1'b1);
      applyStimulus(1);
      checkOutput("pre-reset out_valid", out_valid_o, 1);
      rst = 1'b1;
      #1;
      checkOutput("async reset out_valid", out_valid_o, 0);
      checkOutput("async reset out_data",  out_data_o,  0);
      checkOutput("async reset out_id",    out_id_o,    0);
      checkOutput("async reset in_ready",  in_ready_o,  0);
      reqQ[2].delete();
      drive();
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      pushBeat(0, 32'h55, 1'b1);
      pushBeat(2, 32'h66, 1'b1);
      expectBeat(0, 32'h55, 1'b1);
      expectBeat(2, 32'h66, 1'b1);
      applyStimulus(2);
      applyStimulus(2);

      checkOutput("scoreboard drained", expQ.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/stream_rr_arbiter.md
Name: stream_rr_arbiter

Overview:
Round-robin arbiter that shares one valid/ready stream channel among NUM_REQ requesters. Grants are packet-atomic: once a requester's first beat is accepted, it keeps the grant until its beat with last=1 is accepted. The output stage is a registered slice with full throughput. The block feeds a downstream skid_buffer or consumer and reports the source id with each beat.

Parameters:
NUM_REQ, 4, number of requesters; legal range 1..16.
DATA_WIDTH, 32, payload width per beat.
ID_WIDTH, derived, equal to max(1, $clog2(NUM_REQ)); not user-overridable.

Ports:
clk  input  1  clock; all state changes on its rising edge.
rst  input  1  reset; asynchronous, active-high.
in_valid_i  input  NUM_REQ  per-requester beat valid.
in_ready_o  output  NUM_REQ  per-requester beat accepted; at most one bit high.
in_data_i  input  NUM_REQ*DATA_WIDTH  requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
in_last_i  input  NUM_REQ  per-requester last-beat-of-packet flag.
out_valid_o  output  1  registered output beat valid.
out_ready_i  input  1  downstream ready.
out_data_o  output  DATA_WIDTH  registered payload.
out_last_o  output  1  registered last flag.
out_id_o  output  ID_WIDTH  index of the requester that produced the current output beat.

Behaviour:
- Reset (async assert, sync release):
  - out_valid_o=0, out_data_o=0, out_last_o=0, out_id_o=0.
  - lock=0, lock_id=0, rr_ptr=0 (requester 0 has highest priority).
  - in_ready_o=0 while rst is high.
- load = ~out_valid_o | out_ready_i. A new beat can enter the output register when it is empty or draining in the same cycle.
- Grant, combinational:
  - Unlocked: the first requester with in_valid_i=1, scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - Locked: only lock_id, and only if in_valid_i[lock_id]=1; otherwise no grant, and the other requesters are ignored.
- in_ready_o[g] = load & grant_valid for the granted index g; all other bits are 0.
  - in_ready_o may depend combinationally on in_valid_i and out_ready_i.
  - Requesters must not make in_valid_i depend on in_ready_o.
- Accept (in_valid_i[g] & in_ready_o[g]) at a clock edge:
  - out_data_o, out_last_o and out_id_o take requester g's values; out_valid_o=1.
  - Latency is 1 cycle from acceptance to out_valid_o.
- Accept with in_last_i[g]=0: lock=1, lock_id=g; rr_ptr is unchanged.
- Accept with in_last_i[g]=1: lock=0; rr_ptr=(g+1) mod NUM_REQ. This applies to single-beat packets too.
- out_ready_i=1 with no accept: out_valid_o goes to 0 and the other output registers hold.
- Stall (out_valid_o=1, out_ready_i=0): all output registers hold, all in_ready_o=0, arbitration state holds.
- Full throughput: with continuous valids and out_ready_i=1, one beat is accepted every cycle with no bubbles, including across packet boundaries and requester switches.
- Simultaneous drain and accept in one cycle: the output register is overwritten with the new beat and out_valid_o stays 1.
- Wrap-around: if g=NUM_REQ-1 finishes a packet, rr_ptr=0.
- NUM_REQ=1: degenerates to a registered pipe slice; out_id_o is always 0.
- Reset mid-packet: lock is cleared and any in-flight output beat is dropped. Upstream must also restart its packet.
- Internal state: lock (1b), lock_id (ID_WIDTH), rr_ptr (ID_WIDTH), plus the output register.
- Assertions (sim only):
  - $onehot0(in_ready_o).
  - out_valid_o & ~out_ready_i implies out_data_o/out_last_o/out_id_o are stable next cycle.

Test Plan:
- Reset then idle: rst pulse, all valids 0 -> all outputs 0, in_ready_o=4'b0000 after release, out_valid_o stays 0.
- Round-robin fairness: NUM_REQ=4, all requesters valid with single-beat packets (last=1), data=0x100*i+seq, out_ready_i=1 -> out_id_o sequence 0,1,2,3,0,1..., one beat per cycle, data matches per requester.
- Packet lock: req1 sends 3 beats (last on the 3rd) while req0/req2 are valid -> out_id_o = 1,1,1 with no interleaving, then 2, then 3 or 0 per rr_ptr=2. Insert a 1-cycle in_valid_i[1] gap mid-packet -> an output bubble and no grant to others.
- Backpressure: out_ready_i held low for 5 cycles with beat 0xA5 captured -> out_data_o=0xA5 stable, in_ready_o=0; release -> next beat follows the next cycle with no loss or duplication.
- Wrap and priority: rr_ptr driven to 3 by req2 finishing; req0 and req3 valid -> req3 granted first, then req0; after req3's last, rr_ptr=0.
- Reset mid-packet: assert rst after req2's first non-last beat -> outputs zero immediately (async), lock cleared; after release req0 is granted first.
